// File: rtl/robot_step_scheduler.sv
// Move sequencer around the wall-following robot FSM: settle/latch sensors, take the
// robot's front/rotate decision, hand it to the motor over valid/ready, step the robot once per move.
module robot_step_scheduler #(
  parameter int MOVE_W    = 8,
  parameter int MAX_MOVES = 200,
  parameter int TRAP_ROT  = 4,
  parameter int SETTLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              head_in,
  input  logic              left_in,
  input  logic              front,
  input  logic              rotate,
  output logic              robot_head,
  output logic              robot_left,
  output logic              robot_step,
  output logic              mv_valid,
  output logic [1:0]        mv_cmd,
  input  logic              mv_ready,
  output logic [MOVE_W-1:0] move_count,
  output logic              busy,
  output logic              done,
  output logic              trapped,
  output logic              fault
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int RW = $clog2(TRAP_ROT + 1);
  localparam logic [SW-1:0]     SETTLE_INIT = SW'(SETTLE);
  localparam logic [RW-1:0]     ROT_LAST    = RW'(TRAP_ROT - 1);
  localparam logic [MOVE_W-1:0] MOVE_LAST   = MOVE_W'(MAX_MOVES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SENSE, S_DECIDE, S_CMD, S_DONE, S_TRAP, S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] settle;
  logic [RW-1:0] rot_run;

  logic accept, is_rot, rot_hit, budget_hit, settle_last, dec_ok;

  assign accept      = (state == S_CMD) && mv_ready;
  assign is_rot      = (mv_cmd == 2'b10);
  assign rot_hit     = is_rot && (rot_run == ROT_LAST);
  assign budget_hit  = (move_count == MOVE_LAST);
  assign settle_last = (settle == SW'(1));
  assign dec_ok      = front ^ rotate;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_TRAP, S_FAULT: if (start) state_n = S_SENSE;
      S_SENSE:  if (settle_last) state_n = S_DECIDE;
      S_DECIDE: state_n = dec_ok ? S_CMD : S_FAULT;
      S_CMD: begin
        // trap outranks budget when both land on the same move
        if (mv_ready) begin
          if (rot_hit)         state_n = S_TRAP;
          else if (budget_hit) state_n = S_DONE;
          else                 state_n = S_SENSE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mv_valid   = (state == S_CMD);
    robot_step = accept && !rst;
    busy       = (state == S_SENSE) || (state == S_DECIDE) || (state == S_CMD);
    done       = (state == S_DONE);
    trapped    = (state == S_TRAP);
    fault      = (state == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle     <= '0;
      rot_run    <= '0;
      move_count <= '0;
      robot_head <= 1'b0;
      robot_left <= 1'b0;
      mv_cmd     <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TRAP, S_FAULT: begin
          if (start) begin
            move_count <= '0;
            rot_run    <= '0;
            settle     <= SETTLE_INIT;
          end
        end
        S_SENSE: begin
          settle <= settle - 1'b1;
          if (settle_last) begin
            robot_head <= head_in;
            robot_left <= left_in;
          end
        end
        S_DECIDE: begin
          if (front && !rotate)      mv_cmd <= 2'b01;
          else if (rotate && !front) mv_cmd <= 2'b10;
        end
        S_CMD: begin
          if (mv_ready) begin
            move_count <= move_count + 1'b1;
            rot_run    <= is_rot ? rot_run + 1'b1 : '0;
            settle     <= SETTLE_INIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
